bk_mod_add_pipe: RTL and testbench



---
 rtl/bk_mod_add_pipe.sv | 101 ++++++++++
 tb/tb_bk_mod_add_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bk_mod_add_pipe.sv
// Two-stage elastic modular adder for the Kyber NTT butterfly: S = (A + B) mod Q.
// Both carry chains (raw add, then the subtract-Q compare) use a Brent-Kung prefix network.
module bk_mod_add_pipe #(
  parameter int Q = 3329,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         range_err
);

  // Extended width: one bit for the raw carry, one more as sign for the subtract-Q step.
  localparam int XW = W + 2;
  localparam logic [XW-1:0] Q_X = XW'(Q);
  localparam logic [W-1:0]  Q_W = W'(Q);

  // Brent-Kung prefix adder: up-sweep builds group terms at 2^k-1, down-sweep fills the rest.
  function automatic logic [XW-1:0] bk_add(input logic [XW-1:0] a,
                                           input logic [XW-1:0] b,
                                           input logic          cin);
    logic [XW-1:0] g, p, gg, pp, c;
    g  = a & b;
    p  = a ^ b;
    gg = g;
    pp = p;
    gg[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < XW; d = d * 2) begin
      for (int i = 2 * d - 1; i < XW; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = 1 << $clog2(XW); d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < XW; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c = {gg[XW-2:0], cin};
    return p ^ c;
  endfunction

  // Single conditional subtraction of Q; a negative difference keeps the raw sum.
  function automatic logic [W-1:0] reduce_q(input logic [XW-1:0] s);
    logic signed [XW-1:0] diff;
    diff = signed'(bk_add(s, ~Q_X, 1'b1));
    return (diff < 0) ? s[W-1:0] : diff[W-1:0];
  endfunction

  logic          vld_p1, vld_p2;
  logic          adv1, adv2, accept;
  logic [XW-1:0] sum_p1;
  logic          err_p1;
  logic [W-1:0]  s_p2;

  assign adv2      = ~vld_p2 | out_ready;
  assign adv1      = ~vld_p1 | adv2;
  assign in_ready  = adv1;
  assign accept    = in_valid & adv1 & ~rst;
  assign out_valid = vld_p2;
  assign S         = s_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv2) begin
        vld_p2 <= vld_p1;
        if (vld_p1 && err_p1) range_err <= 1'b1;
      end
    end
  end

  // Stage 1: raw sum and operand range flag
  always_ff @(posedge clk) begin
    if (accept) begin
      sum_p1 <= bk_add({2'b00, A}, {2'b00, B}, 1'b0);
      err_p1 <= (A >= Q_W) | (B >= Q_W);
    end
  end

  // Stage 2: reduction into [0, Q); S is cleared by reset so no stale value shows
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p2 <= '0;
    end else if (adv2 && vld_p1) begin
      s_p2 <= reduce_q(sum_p1);
    end
  end

endmodule

// File: tb/tb_bk_mod_add_pipe.sv
// Bench for bk_mod_add_pipe: directed cases plus randomized streaming, checked by a
// scoreboard queue fed at accept time and drained by an independent output monitor.
module tb_bk_mod_add_pipe;
  localparam int Q = 3329;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         range_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int exp_s[$];
  int exp_cyc[$];
  bit exp_lat[$];

  bk_mod_add_pipe #(.Q(Q), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .S(S),
    .range_err(range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the sum of two values is reduced by at most one subtraction of Q.
  function automatic int ref_mod_add(input int a, input int b);
    int s;
    s = a + b;
    return (s >= Q) ? s - Q : s;
  endfunction

  task automatic push(input int a, input int b, input bit lat);
    exp_s.push_back(ref_mod_add(a, b));
    exp_cyc.push_back(cyc);
    exp_lat.push_back(lat);
  endtask

  // Present one item and hold it until accepted; the push happens at the accepting cycle.
  task automatic send(input int a, input int b, input bit lat);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    A = a[W-1:0];
    B = b[W-1:0];
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) push(a, b, lat);
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor
  initial begin
    int e, c;
    bit l;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_s.size() == 0) begin
          check("unexpected_output", int'(S), -1);
        end else begin
          e = exp_s.pop_front();
          c = exp_cyc.pop_front();
          l = exp_lat.pop_front();
          check("S", int'(S), e);
          if (l) check("latency", cyc - c, 2);
        end
      end
    end
  end

  initial begin
    int sent, a, b, n;
    bit hold;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;

    // Test 1: reset state and a sum landing exactly on Q
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_S", int'(S), 0);
    check("rst_range_err", int'(range_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send(3328, 1, 1'b1);
    idle(3);
    check("t1_range_err", int'(range_err), 0);

    // Test 2: back-to-back boundary items
    send(3328, 3328, 1'b1);
    send(0, 0, 1'b1);
    send(1664, 1664, 1'b1);
    send(3000, 328, 1'b1);
    send(3000, 327, 1'b1);
    idle(4);

    // Test 3: downstream stall fills both stages, then releases in order
    out_ready = 1'b0;
    send(1000, 2000, 1'b0);
    send(3000, 1000, 1'b0);
    in_valid = 1'b1;
    A = 16'd2;
    B = 16'd3;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_S", int'(S), 3000);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2, 3, 1'b0);
    send(3328, 0, 1'b0);
    idle(5);
    check("t3_drained", exp_s.size(), 0);

    // Test 4: out-of-range operand sets the sticky flag
    send(4000, 0, 1'b1);
    idle(3);
    check("t4_range_err_set", int'(range_err), 1);
    send(5, 5, 1'b1);
    idle(4);
    check("t4_range_err_sticky", int'(range_err), 1);

    // Test 5: reset with both stages full and output stalled
    out_ready = 1'b0;
    send(10, 20, 1'b0);
    send(30, 40, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    A = 16'd9;
    B = 16'd9;
    exp_s.delete();
    exp_cyc.delete();
    exp_lat.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_range_err", int'(range_err), 0);
    check("t5_S", int'(S), 0);
    @(posedge clk);
    #1;
    send(5, 7, 1'b1);
    idle(4);
    check("t5_drained", exp_s.size(), 0);

    // Test 6: random operands with random valid and ready
    sent = 0;
    hold = 1'b0;
    while (sent < 10000) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 1) != 0);
        a = int'($urandom_range(0, Q - 1));
        b = int'($urandom_range(0, Q - 1));
        A = a[W-1:0];
        B = b[W-1:0];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        push(a, b, 1'b0);
        sent++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_s.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check("t6_drained", exp_s.size(), 0);
    check("t6_range_err", int'(range_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
